capture_ctrl: RTL and testbench

//  Capture sequencer downstream of the trigger stage. Decimates the sample clock and

---
 rtl/capture_pkg.sv | 20 ++
 rtl/capture_decimator.sv | 41 ++++
 rtl/capture_ctrl.sv | 144 ++++++++++++++
 tb/tb_capture_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | capture_pkg : shared types and default widths for the capture sequencer      |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
package capture_pkg;

  localparam int c_DEF_ADDR_W = 9;
  localparam int c_DEF_DEC_W  = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4
  } cap_state_t;

endpackage
`default_nettype wire

// File: rtl/capture_decimator.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | capture_decimator : sample-enable generator, one pulse every 2**dec clocks   |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
module capture_decimator
  import capture_pkg::*;
#(
  parameter int DEC_W = c_DEF_DEC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  input  logic [DEC_W-1:0] dec,
  output logic             smp_en
);

  // Wide enough to hold 2**dec-1 for the largest dec the field can express.
  localparam int CNT_W = (1 << DEC_W) - 1;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_mask;
  logic             w_hit;

  assign w_mask = ~({CNT_W{1'b1}} << dec);
  assign w_hit  = (r_cnt == w_mask);
  assign smp_en = en & w_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_hit ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/capture_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | capture_ctrl : capture sequencer writing decimated samples into a ring RAM   |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
module capture_ctrl
  import capture_pkg::*;
#(
  parameter int ADDR_W = c_DEF_ADDR_W,
  parameter int DEC_W  = c_DEF_DEC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture_start,
  input  logic              abort,
  input  logic              clr_capture_done,
  input  logic              trigger,
  input  logic [ADDR_W-1:0] trig_pos,
  input  logic [DEC_W-1:0]  decimator,
  output logic              armed,
  output logic              set_capture_done,
  output logic              capture_done,
  output logic              busy,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W-1:0] trig_addr
);

  localparam logic [ADDR_W:0] c_DEPTH = {1'b1, {ADDR_W{1'b0}}};

  cap_state_t        r_state;
  logic [ADDR_W-1:0] r_trig_pos;
  logic [DEC_W-1:0]  r_dec;
  logic [ADDR_W-1:0] r_waddr;
  logic [ADDR_W-1:0] r_trig_addr;
  logic [ADDR_W:0]   r_pre_cnt;
  logic [ADDR_W-1:0] r_post_cnt;
  logic              r_set_done;

  logic              w_active;
  logic              w_smp_en;
  logic              w_we;
  logic [ADDR_W:0]   w_pre_target;
  logic              w_pre_hit;
  logic              w_post_hit;

  assign w_active = (r_state == FILL) || (r_state == ARMED) || (r_state == POST);
  // A zero-length post region must not write anything while passing through POST.
  assign w_we = w_smp_en &&
                ((r_state == FILL) || (r_state == ARMED) ||
                 ((r_state == POST) && (r_trig_pos != '0)));

  assign w_pre_target = c_DEPTH - {1'b0, r_trig_pos};
  assign w_pre_hit    = ((r_pre_cnt + (ADDR_W+1)'(1)) == w_pre_target);
  assign w_post_hit   = ((r_post_cnt + ADDR_W'(1)) == r_trig_pos);

  capture_decimator #(
    .DEC_W (DEC_W)
  ) u_dec (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (r_state == IDLE),
    .en     (w_active),
    .dec    (r_dec),
    .smp_en (w_smp_en)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_trig_pos  <= '0;
      r_dec       <= '0;
      r_waddr     <= '0;
      r_trig_addr <= '0;
      r_pre_cnt   <= '0;
      r_post_cnt  <= '0;
      r_set_done  <= 1'b0;
    end else begin
      r_set_done <= 1'b0;
      if (w_we) begin
        r_waddr <= r_waddr + ADDR_W'(1);
      end
      if (abort && (r_state != IDLE)) begin
        r_state    <= IDLE;
        r_set_done <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            if (capture_start) begin
              r_trig_pos <= trig_pos;
              r_dec      <= decimator;
              r_waddr    <= '0;
              r_pre_cnt  <= '0;
              r_post_cnt <= '0;
              r_state    <= FILL;
            end
          end
          FILL: begin
            if (w_we) begin
              r_pre_cnt <= r_pre_cnt + (ADDR_W+1)'(1);
              if (w_pre_hit) begin
                r_state <= ARMED;
              end
            end
          end
          ARMED: begin
            if (trigger) begin
              r_trig_addr <= r_waddr;
              r_state     <= POST;
            end
          end
          POST: begin
            if (r_trig_pos == '0) begin
              r_state    <= DONE;
              r_set_done <= 1'b1;
            end else if (w_we) begin
              r_post_cnt <= r_post_cnt + ADDR_W'(1);
              if (w_post_hit) begin
                r_state    <= DONE;
                r_set_done <= 1'b1;
              end
            end
          end
          DONE: begin
            if (clr_capture_done) begin
              r_state <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign armed            = (r_state == ARMED);
  assign capture_done     = (r_state == DONE);
  assign busy             = w_active;
  assign we               = w_we;
  assign waddr            = r_waddr;
  assign trig_addr        = r_trig_addr;
  assign set_capture_done = r_set_done;

endmodule
`default_nettype wire

// File: tb/tb_capture_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_capture_ctrl : directed self-checking bench for capture_ctrl              |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
module tb_capture_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       capture_start, abort, clr_capture_done, trigger;
  logic [8:0] trig_pos;
  logic [3:0] decimator;
  logic       armed, set_capture_done, capture_done, busy, we;
  logic [8:0] waddr, trig_addr;

  int n_vec = 0;
  int n_err = 0;
  int wcnt;
  int cyc;
  int lim;
  logic saw_wrap;
  logic [8:0] exp_taddr;

  always #5 clk = ~clk;

  capture_ctrl u_dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .capture_start    (capture_start),
    .abort            (abort),
    .clr_capture_done (clr_capture_done),
    .trigger          (trigger),
    .trig_pos         (trig_pos),
    .decimator        (decimator),
    .armed            (armed),
    .set_capture_done (set_capture_done),
    .capture_done     (capture_done),
    .busy             (busy),
    .we               (we),
    .waddr            (waddr),
    .trig_addr        (trig_addr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Counts the write committed at the coming edge, then samples 1ns after it.
  task automatic tick();
    if (we) wcnt++;
    if (we && armed && waddr == 9'd511) saw_wrap = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic start_capture(input logic [8:0] tp, input logic [3:0] dc);
    trig_pos = tp; decimator = dc; capture_start = 1'b1;
    tick();
    capture_start = 1'b0;
    trig_pos = 9'd77; decimator = 4'd7;
  endtask

  task automatic wait_armed(input int limit);
    cyc = 0; wcnt = 0;
    while (!armed && cyc < limit) begin
      tick();
      cyc++;
    end
  endtask

  task automatic wait_done(input int limit);
    lim = 0;
    while (!set_capture_done && lim < limit) begin
      tick();
      lim++;
    end
  endtask

  initial begin
    rst_n = 1'b0; capture_start = 1'b0; abort = 1'b0; clr_capture_done = 1'b0;
    trigger = 1'b0; trig_pos = '0; decimator = '0; wcnt = 0; saw_wrap = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_flags", {27'd0, armed, set_capture_done, capture_done, busy, we}, 32'd0);
    check("rst_waddr", {23'd0, waddr}, 32'd0);
    check("rst_taddr", {23'd0, trig_addr}, 32'd0);
    rst_n = 1'b1;
    tick();

    // dec=0, trig_pos=100
    start_capture(9'd100, 4'd0);
    check("t1_busy", {31'd0, busy}, 32'd1);
    wait_armed(600);
    check("t1_pre_writes", wcnt, 412);
    check("t1_arm_cycles", cyc, 412);
    check("t1_armed", {31'd0, armed}, 32'd1);
    check("t1_waddr_arm", {23'd0, waddr}, 32'd412);
    exp_taddr = waddr;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    check("t1_post_armed", {31'd0, armed}, 32'd0);
    wcnt = 0;
    wait_done(300);
    check("t1_post_writes", wcnt, 100);
    check("t1_scd", {31'd0, set_capture_done}, 32'd1);
    check("t1_trig_addr", {23'd0, trig_addr}, {23'd0, exp_taddr});
    check("t1_done_we_busy", {30'd0, we, busy}, 32'd0);
    tick();
    check("t1_scd_pulse", {31'd0, set_capture_done}, 32'd0);
    check("t1_cd_held", {31'd0, capture_done}, 32'd1);
    check("t1_waddr_end", {23'd0, waddr}, 32'd1);

    // DONE: start alone ignored; start with clear returns to IDLE only
    capture_start = 1'b1;
    tick();
    capture_start = 1'b0;
    check("done_start_ign", {30'd0, capture_done, busy}, 32'd2);
    capture_start = 1'b1; clr_capture_done = 1'b1;
    tick();
    capture_start = 1'b0; clr_capture_done = 1'b0;
    check("done_clr_start", {30'd0, capture_done, busy}, 32'd0);
    tick();
    check("done_start_drop", {31'd0, busy}, 32'd0);

    // dec=2, trig_pos=500, ring wrap while ARMED, then abort mid-POST
    start_capture(9'd500, 4'd2);
    wait_armed(200);
    check("t2_arm_cycles", cyc, 48);
    check("t2_pre_writes", wcnt, 12);
    saw_wrap = 1'b0;
    repeat (2100) tick();
    check("t2_wrap_seen", {31'd0, saw_wrap}, 32'd1);
    check("t2_waddr_ring", {23'd0, waddr}, 32'd25);
    check("t2_still_armed", {31'd0, armed}, 32'd1);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    repeat (20) tick();
    check("t2_post_busy", {30'd0, armed, busy}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t2_abort_scd", {31'd0, set_capture_done}, 32'd1);
    check("t2_abort_outs", {28'd0, armed, capture_done, busy, we}, 32'd0);
    tick();
    check("t2_abort_pulse", {31'd0, set_capture_done}, 32'd0);

    // trig_pos=0, trigger held during FILL
    trigger = 1'b1;
    start_capture(9'd0, 4'd0);
    repeat (100) tick();
    check("t3_fill_hold", {30'd0, armed, busy}, 32'd1);
    wait_armed(600);
    check("t3_pre_writes", wcnt, 412);
    check("t3_arm_cycles", cyc, 412);
    tick();
    wcnt = 0;
    check("t3_post_noarm", {30'd0, armed, we}, 32'd0);
    tick();
    trigger = 1'b0;
    check("t3_post_writes", wcnt, 0);
    check("t3_done", {30'd0, set_capture_done, capture_done}, 32'd3);
    clr_capture_done = 1'b1;
    tick();
    clr_capture_done = 1'b0;
    check("t3_idle", {30'd0, capture_done, busy}, 32'd0);

    // async reset mid-FILL
    start_capture(9'd10, 4'd3);
    repeat (20) tick();
    check("t4_fill_waddr", {23'd0, waddr}, 32'd2);
    #3;
    rst_n = 1'b0;
    #1;
    check("t4_rst_flags", {27'd0, armed, set_capture_done, capture_done, busy, we}, 32'd0);
    check("t4_rst_waddr", {23'd0, waddr}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
